// File: rtl/id_pkg.sv
// -----------------------------------------------------------------------------
// id_pkg
//   Shared definitions for the ARM-subset decode stage: instruction field
//   encodings (mode, opcode, condition), the ALU command encoding handed to
//   EXE, the packed control bundle, and the condition-check function that
//   evaluates a condition code against the {N,Z,C,V} status flags.
// -----------------------------------------------------------------------------
package id_pkg;

  // Instruction class, Instruction[27:26]
  localparam logic [1:0] MODE_ALU = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  // Data-processing opcodes, Instruction[24:21]
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  // ALU commands understood by EXE
  typedef logic [3:0] exe_cmd_t;
  localparam exe_cmd_t CMD_MOV = 4'b0001;
  localparam exe_cmd_t CMD_ADD = 4'b0010;
  localparam exe_cmd_t CMD_ADC = 4'b0011;
  localparam exe_cmd_t CMD_SUB = 4'b0100;
  localparam exe_cmd_t CMD_SBC = 4'b0101;
  localparam exe_cmd_t CMD_AND = 4'b0110;
  localparam exe_cmd_t CMD_ORR = 4'b0111;
  localparam exe_cmd_t CMD_EOR = 4'b1000;
  localparam exe_cmd_t CMD_MVN = 4'b1001;

  // Condition codes, Instruction[31:28]; 4'b1111 is never executed
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Control bits carried through ID/EXE
  typedef struct packed {
    logic     wb_en;
    logic     mem_r_en;
    logic     mem_w_en;
    logic     b;
    logic     s;
    exe_cmd_t exe_cmd;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // Register address width: enough for NUM_REGS, never below the 4-bit
  // register fields of the instruction.
  function automatic int addr_width(input int num_regs);
    int w;
    w = $clog2(num_regs);
    return (w < 4) ? 4 : w;
  endfunction

  // True when the condition code holds for the given {N,Z,C,V} flags.
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] sr);
    logic n, z, c, v;
    logic pass;
    {n, z, c, v} = sr;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/id_decode_stage_if.sv
// -----------------------------------------------------------------------------
// id_decode_stage_if
//   Bundles the decode stage's signals other than clock and reset.
//   master: the surrounding pipeline (drives IF/ID, WB, hazard and flush,
//           consumes hazard sources and the ID/EXE register).
//   slave : the decode stage itself.
//   Inputs : In_Valid, PC_In, Instruction, SR, hazard, Flush,
//            writeBackEn, Dest_wb, Result_WB
//   Outputs: src1, src2, Two_src (combinational),
//            Valid_Out, PC_Out, WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD,
//            Val_Rn, Val_Rm, imm, Shift_operand, Signed_imm_24, Dest
// -----------------------------------------------------------------------------
interface id_decode_stage_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
);
  localparam int ADDR_W = id_pkg::addr_width(NUM_REGS);

  logic              In_Valid;
  logic [31:0]       PC_In;
  logic [31:0]       Instruction;
  logic [3:0]        SR;
  logic              hazard;
  logic              Flush;
  logic              writeBackEn;
  logic [ADDR_W-1:0] Dest_wb;
  logic [DATA_W-1:0] Result_WB;

  logic [ADDR_W-1:0] src1;
  logic [ADDR_W-1:0] src2;
  logic              Two_src;

  logic              Valid_Out;
  logic [31:0]       PC_Out;
  logic              WB_EN;
  logic              MEM_R_EN;
  logic              MEM_W_EN;
  logic              B;
  logic              S;
  logic [3:0]        EXE_CMD;
  logic [DATA_W-1:0] Val_Rn;
  logic [DATA_W-1:0] Val_Rm;
  logic              imm;
  logic [11:0]       Shift_operand;
  logic [23:0]       Signed_imm_24;
  logic [ADDR_W-1:0] Dest;

  modport master (
    output In_Valid, PC_In, Instruction, SR, hazard, Flush,
           writeBackEn, Dest_wb, Result_WB,
    input  src1, src2, Two_src,
           Valid_Out, PC_Out, WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD,
           Val_Rn, Val_Rm, imm, Shift_operand, Signed_imm_24, Dest
  );

  modport slave (
    input  In_Valid, PC_In, Instruction, SR, hazard, Flush,
           writeBackEn, Dest_wb, Result_WB,
    output src1, src2, Two_src,
           Valid_Out, PC_Out, WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD,
           Val_Rn, Val_Rm, imm, Shift_operand, Signed_imm_24, Dest
  );

endinterface

// File: rtl/id_regfile.sv
// -----------------------------------------------------------------------------
// id_regfile
//   NUM_REGS x DATA_W register file, one write port, two combinational read
//   ports. Synchronous active-high reset loads every register with its own
//   index. With BYPASS_EN set, a read of the register being written in the
//   same cycle returns the incoming write data.
//   clk, rst            : clock, synchronous active-high reset
//   we_i/waddr_i/wdata_i: write-back port
//   raddr1_i/rdata1_o   : Rn read port
//   raddr2_i/rdata2_o   : Rm / Rd read port
// -----------------------------------------------------------------------------
module id_regfile #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 16,
  parameter int ADDR_W    = 4,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // NOTE: this array is reset on purpose -- software relies on reg[i] == i
  // after reset, so it cannot be left to map onto an unreset RAM macro.
  // Reset takes priority over a write-back landing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= DATA_W'(i);
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    rdata2_o = regs_q[raddr2_i];
    if (BYPASS_EN && we_i && (raddr1_i == waddr_i)) rdata1_o = wdata_i;
    if (BYPASS_EN && we_i && (raddr2_i == waddr_i)) rdata2_o = wdata_i;
  end

endmodule

// File: rtl/id_decode_stage.sv
// -----------------------------------------------------------------------------
// id_decode_stage
//   ARM-subset instruction decode with the ID/EXE pipeline register folded in.
//   Reads operands from the register file (with write-back bypass), decodes
//   the control bits, checks the condition code against SR, and registers the
//   result. Hazard, a failed condition or an empty IF/ID slot turn the cycle
//   into a bubble; Flush clears the register outright.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : id_decode_stage_if slave (IF/ID inputs, WB port, hazard/flush,
//              combinational src1/src2/Two_src, registered ID/EXE outputs)
// -----------------------------------------------------------------------------
module id_decode_stage
  import id_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 16,
  parameter bit BYPASS_EN = 1'b1
) (
  input logic              CLK,
  input logic              RST,
  id_decode_stage_if.slave bus
);

  localparam int ADDR_W = addr_width(NUM_REGS);

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    ctrl_t             ctrl;
    logic [DATA_W-1:0] val_rn;
    logic [DATA_W-1:0] val_rm;
    logic              imm;
    logic [11:0]       shift_operand;
    logic [23:0]       signed_imm_24;
    logic [ADDR_W-1:0] dest;
  } idex_t;

  // Instruction fields
  logic [3:0] cond;
  logic [1:0] mode;
  logic       imm_bit;
  logic [3:0] opcode;
  logic       s_bit;
  logic [3:0] rn_field;
  logic [3:0] rd_field;
  logic [3:0] rm_field;

  assign cond     = bus.Instruction[31:28];
  assign mode     = bus.Instruction[27:26];
  assign imm_bit  = bus.Instruction[25];
  assign opcode   = bus.Instruction[24:21];
  assign s_bit    = bus.Instruction[20];
  assign rn_field = bus.Instruction[19:16];
  assign rd_field = bus.Instruction[15:12];
  assign rm_field = bus.Instruction[3:0];

  ctrl_t             ctrl;
  logic [ADDR_W-1:0] src1;
  logic [ADDR_W-1:0] src2;
  logic              cond_ok;
  logic              load;
  logic [DATA_W-1:0] val_rn;
  logic [DATA_W-1:0] val_rm;
  idex_t             idex_d;
  idex_t             idex_q;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  // NOTE: every output of a combinational block gets a default before any
  // branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    ctrl = CTRL_NONE;
    case (mode)
      MODE_ALU: begin
        ctrl.s = s_bit;
        case (opcode)
          OP_MOV:  begin ctrl.exe_cmd = CMD_MOV; ctrl.wb_en = 1'b1; end
          OP_MVN:  begin ctrl.exe_cmd = CMD_MVN; ctrl.wb_en = 1'b1; end
          OP_ADD:  begin ctrl.exe_cmd = CMD_ADD; ctrl.wb_en = 1'b1; end
          OP_ADC:  begin ctrl.exe_cmd = CMD_ADC; ctrl.wb_en = 1'b1; end
          OP_SUB:  begin ctrl.exe_cmd = CMD_SUB; ctrl.wb_en = 1'b1; end
          OP_SBC:  begin ctrl.exe_cmd = CMD_SBC; ctrl.wb_en = 1'b1; end
          OP_AND:  begin ctrl.exe_cmd = CMD_AND; ctrl.wb_en = 1'b1; end
          OP_ORR:  begin ctrl.exe_cmd = CMD_ORR; ctrl.wb_en = 1'b1; end
          OP_EOR:  begin ctrl.exe_cmd = CMD_EOR; ctrl.wb_en = 1'b1; end
          // Compares only update flags: no register write-back
          OP_CMP:  ctrl.exe_cmd = CMD_SUB;
          OP_TST:  ctrl.exe_cmd = CMD_AND;
          default: ctrl = CTRL_NONE;
        endcase
      end
      MODE_MEM: begin
        // Address is always Rn + offset; bit 20 selects load vs store
        ctrl.exe_cmd = CMD_ADD;
        if (s_bit) begin
          ctrl.mem_r_en = 1'b1;
          ctrl.wb_en    = 1'b1;
        end else begin
          ctrl.mem_w_en = 1'b1;
        end
      end
      MODE_BR: ctrl.b = 1'b1;
      default: ctrl = CTRL_NONE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Hazard-unit sources: pure functions of the instruction word. A store reads
  // Rd as its data operand, so src2 switches to Rd for stores.
  // ---------------------------------------------------------------------------
  assign src1 = ADDR_W'(rn_field);
  assign src2 = ctrl.mem_w_en ? ADDR_W'(rd_field) : ADDR_W'(rm_field);

  assign bus.src1    = src1;
  assign bus.src2    = src2;
  assign bus.Two_src = ((mode == MODE_ALU) && !imm_bit) || ctrl.mem_w_en;

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  id_regfile #(
    .DATA_W    (DATA_W),
    .NUM_REGS  (NUM_REGS),
    .ADDR_W    (ADDR_W),
    .BYPASS_EN (BYPASS_EN)
  ) u_regfile (
    .clk      (CLK),
    .rst      (RST),
    .we_i     (bus.writeBackEn),
    .waddr_i  (bus.Dest_wb),
    .wdata_i  (bus.Result_WB),
    .raddr1_i (src1),
    .raddr2_i (src2),
    .rdata1_o (val_rn),
    .rdata2_o (val_rm)
  );

  // ---------------------------------------------------------------------------
  // ID/EXE register. A bubble and a flush both leave the register all-zero;
  // they differ only in that Flush is not gated by In_Valid or the condition.
  // ---------------------------------------------------------------------------
  assign cond_ok = cond_check(cond, bus.SR);
  assign load    = bus.In_Valid && !bus.hazard && cond_ok;

  always_comb begin
    idex_d = '0;
    if (!bus.Flush && load) begin
      idex_d.valid         = 1'b1;
      idex_d.pc            = bus.PC_In;
      idex_d.ctrl          = ctrl;
      idex_d.val_rn        = val_rn;
      idex_d.val_rm        = val_rm;
      idex_d.imm           = imm_bit;
      idex_d.shift_operand = bus.Instruction[11:0];
      idex_d.signed_imm_24 = bus.Instruction[23:0];
      idex_d.dest          = ADDR_W'(rd_field);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK) begin
    if (RST) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign bus.Valid_Out     = idex_q.valid;
  assign bus.PC_Out        = idex_q.pc;
  assign bus.WB_EN         = idex_q.ctrl.wb_en;
  assign bus.MEM_R_EN      = idex_q.ctrl.mem_r_en;
  assign bus.MEM_W_EN      = idex_q.ctrl.mem_w_en;
  assign bus.B             = idex_q.ctrl.b;
  assign bus.S             = idex_q.ctrl.s;
  assign bus.EXE_CMD       = idex_q.ctrl.exe_cmd;
  assign bus.Val_Rn        = idex_q.val_rn;
  assign bus.Val_Rm        = idex_q.val_rm;
  assign bus.imm           = idex_q.imm;
  assign bus.Shift_operand = idex_q.shift_operand;
  assign bus.Signed_imm_24 = idex_q.signed_imm_24;
  assign bus.Dest          = idex_q.dest;

endmodule
